// File: rtl/lfsr_gen_if.sv
// Control/status bundle for lfsr_gen.
// The master side (pin wrapper or bench) drives en, load, seed_in, mode and
// taps_in. The slave side (the generator) returns the registered state lfsr,
// the one-cycle pulses wrap and lockup, the measured period and period_valid.
interface lfsr_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [1:0]       mode;
    logic [WIDTH-1:0] taps_in;
    logic [WIDTH-1:0] lfsr;
    logic             wrap;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             lockup;

    modport master (
        output en, load, seed_in, mode, taps_in,
        input  lfsr, wrap, period, period_valid, lockup
    );

    modport slave (
        input  en, load, seed_in, mode, taps_in,
        output lfsr, wrap, period, period_valid, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised N-bit LFSR with Fibonacci/Galois structure, built-in
// maximal-length or custom taps, seed load, zero-state lockup recovery and
// period measurement against a reference state.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - lfsr_gen_if.slave: en, load, seed_in, mode, taps_in in;
//           lfsr, wrap, period, period_valid, lockup out (all registered)
// mode[0]: 0=Fibonacci, 1=Galois. mode[1]: 0=built-in taps, 1=taps_in.
// Tap mask bit k-1 stands for the polynomial term x^k.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    lfsr_gen_if.slave  bus
);

    // Maximal-length masks for each supported width, stored 16 bits wide.
    function automatic logic [15:0] builtin_mask(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] m);
        return {s[WIDTH-2:0], ^(s & m)};
    endfunction

    // Galois: shift left, and when the bit shifted out is 1 fold the mask
    // back in (bit 0 always receives the shifted-out 1).
    function automatic logic [WIDTH-1:0] gal_step(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] fold;
        if (s[WIDTH-1]) begin
            fold = {m[WIDTH-2:0], 1'b1};
        end else begin
            fold = {WIDTH{1'b0}};
        end
        return {s[WIDTH-2:0], 1'b0} ^ fold;
    endfunction

    localparam logic [15:0]      BUILTIN16 = builtin_mask(WIDTH);
    localparam logic [WIDTH-1:0] BUILTIN   = BUILTIN16[WIDTH-1:0];

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_ref;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_wrap;
    logic             r_lockup;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_taps;

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_next;
    logic [CNT_W-1:0] w_count_inc;
    logic [WIDTH-1:0] w_seed;
    logic             w_seed_zero;
    logic             w_cfg_change;

    // Next-state datapath: mask select, step, saturating count, seed fallback.
    always_comb begin
        w_mask       = BUILTIN;
        w_next       = r_lfsr;
        w_count_inc  = r_count;
        w_seed       = bus.seed_in;
        w_seed_zero  = 1'b0;
        w_cfg_change = (bus.mode != r_mode) || (bus.taps_in != r_taps);

        // Stepping only happens when the inputs equal the registered copy,
        // so the copy is the config in force for any step.
        if (r_mode[1]) begin
            w_mask = r_taps;
        end else begin
            w_mask = BUILTIN;
        end

        if (r_mode[0]) begin
            w_next = gal_step(r_lfsr, w_mask);
        end else begin
            w_next = fib_step(r_lfsr, w_mask);
        end

        if (&r_count) begin
            w_count_inc = r_count;
        end else begin
            w_count_inc = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (bus.seed_in == {WIDTH{1'b0}}) begin
            w_seed      = SEED;
            w_seed_zero = 1'b1;
        end else begin
            w_seed      = bus.seed_in;
            w_seed_zero = 1'b0;
        end
    end

    // State register: reset > load > config change > en step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr         <= SEED;
            r_ref          <= SEED;
            r_count        <= {CNT_W{1'b0}};
            r_period       <= {CNT_W{1'b0}};
            r_period_valid <= 1'b0;
            r_wrap         <= 1'b0;
            r_lockup       <= 1'b0;
            // Capture the config present during reset so release is not
            // mistaken for a config change.
            r_mode         <= bus.mode;
            r_taps         <= bus.taps_in;
        end else begin
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
            r_mode   <= bus.mode;
            r_taps   <= bus.taps_in;
            if (bus.load) begin
                r_lfsr         <= w_seed;
                r_ref          <= w_seed;
                r_count        <= {CNT_W{1'b0}};
                r_period_valid <= 1'b0;
                r_lockup       <= w_seed_zero;
            end else if (w_cfg_change) begin
                // Restart the measurement from wherever the sequence is now.
                r_ref          <= r_lfsr;
                r_count        <= {CNT_W{1'b0}};
                r_period_valid <= 1'b0;
            end else if (bus.en) begin
                if (r_lfsr == {WIDTH{1'b0}}) begin
                    // Zero is a fixed point of every mask; restart from ref.
                    r_lfsr   <= r_ref;
                    r_lockup <= 1'b1;
                end else begin
                    r_lfsr <= w_next;
                    if (w_next == r_ref) begin
                        r_wrap         <= 1'b1;
                        r_period       <= w_count_inc;
                        r_period_valid <= 1'b1;
                        r_count        <= {CNT_W{1'b0}};
                    end else begin
                        r_count <= w_count_inc;
                    end
                end
            end else begin
                r_lfsr <= r_lfsr;
            end
        end
    end

    assign bus.lfsr         = r_lfsr;
    assign bus.wrap         = r_wrap;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.lockup       = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: stimulus pushes hand-computed expectations,
// monitors pop and compare when the DUT presents an output.
module tb_lfsr_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(4),  .CNT_W(16)) if4 ();
    lfsr_gen_if #(.WIDTH(8),  .CNT_W(4))  if8 ();
    lfsr_gen_if #(.WIDTH(16), .CNT_W(16)) if16 ();

    lfsr_gen #(.WIDTH(4), .SEED(4'h1), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset), .bus(if4));
    lfsr_gen #(.WIDTH(8), .SEED(8'h01), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .bus(if8));
    lfsr_gen #(.WIDTH(16), .SEED(16'h0001), .CNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .bus(if16));

    typedef struct {
        logic [3:0]  lfsr;
        logic        wrap;
        logic        lockup;
        logic        pv;
        logic [15:0] period;
    } exp_t;

    typedef struct {
        int steps;
        int per;
    } lexp_t;

    exp_t  exp_q[$];
    string name_q[$];
    lexp_t lq8[$];
    lexp_t lq16[$];

    int checks = 0;
    int errors = 0;
    bit run8  = 1'b0;
    bit run16 = 1'b0;
    int cnt8  = 0;
    int cnt16 = 0;

    // Hand-computed sequences from seed 1 (state after each of 15 steps).
    logic [3:0] fib_s [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                               4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] gal_s [15] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7, 4'hE,
                               4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC, 4'h1};
    logic [3:0] cus8_s [5] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

    task automatic drive(input logic en, input logic ld, input logic [3:0] seed,
                         input logic [1:0] md, input logic [3:0] tp, input string nm,
                         input logic [3:0] el, input logic ew, input logic elk,
                         input logic epv, input logic [15:0] ep);
        exp_t e;
        @(negedge clk);
        if4.en = en; if4.load = ld; if4.seed_in = seed;
        if4.mode = md; if4.taps_in = tp;
        e.lfsr = el; e.wrap = ew; e.lockup = elk; e.pv = epv; e.period = ep;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor for the 4-bit DUT: output is presented after each clock edge
    // and immediately after an asynchronous reset assertion.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (if4.lfsr !== e.lfsr || if4.wrap !== e.wrap || if4.lockup !== e.lockup ||
                    if4.period_valid !== e.pv || if4.period !== e.period) begin
                    errors++;
                    $display("FAIL %s: got lfsr=%h wrap=%b lockup=%b pv=%b period=%0d, want lfsr=%h wrap=%b lockup=%b pv=%b period=%0d",
                             nm, if4.lfsr, if4.wrap, if4.lockup, if4.period_valid, if4.period,
                             e.lfsr, e.wrap, e.lockup, e.pv, e.period);
                end
            end
        end
    end

    // Monitors for the long runs: wrap is the valid strobe.
    initial begin
        lexp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (run8) begin
                cnt8++;
                if (if8.wrap) begin
                    checks++;
                    if (lq8.size() > 0) begin
                        e = lq8.pop_front();
                        if (cnt8 != e.steps || int'(if8.period) != e.per || if8.period_valid !== 1'b1) begin
                            errors++;
                            $display("FAIL w8_wrap: got steps=%0d period=%0d pv=%b, want steps=%0d period=%0d pv=1",
                                     cnt8, if8.period, if8.period_valid, e.steps, e.per);
                        end
                    end else begin
                        errors++;
                        $display("FAIL w8_extra_wrap: got wrap at step %0d, want none", cnt8);
                    end
                end
            end
            if (run16) begin
                cnt16++;
                if (if16.wrap) begin
                    checks++;
                    if (lq16.size() > 0) begin
                        e = lq16.pop_front();
                        if (cnt16 != e.steps || int'(if16.period) != e.per || if16.period_valid !== 1'b1) begin
                            errors++;
                            $display("FAIL w16_wrap: got steps=%0d period=%0d pv=%b, want steps=%0d period=%0d pv=1",
                                     cnt16, if16.period, if16.period_valid, e.steps, e.per);
                        end
                    end else begin
                        errors++;
                        $display("FAIL w16_extra_wrap: got wrap at step %0d, want none", cnt16);
                    end
                end
            end
        end
    end

    initial begin
        lexp_t le;
        reset = 1'b1;
        if4.en = 1'b0;  if4.load = 1'b0;  if4.seed_in = 4'h0;     if4.mode = 2'b00;  if4.taps_in = 4'h0;
        if8.en = 1'b0;  if8.load = 1'b0;  if8.seed_in = 8'h00;    if8.mode = 2'b00;  if8.taps_in = 8'h00;
        if16.en = 1'b0; if16.load = 1'b0; if16.seed_in = 16'h0000; if16.mode = 2'b00; if16.taps_in = 16'h0000;

        drive(1'b0, 1'b0, 4'h0, 2'b00, 4'h0, "reset_state", 4'h1, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fibonacci, built-in taps
        drive(1'b0, 1'b1, 4'h1, 2'b00, 4'h0, "t1_load", 4'h1, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 15; i++)
            drive(1'b1, 1'b0, 4'h1, 2'b00, 4'h0, $sformatf("t1_fib%0d", i), fib_s[i],
                  i == 14, 1'b0, i == 14, (i == 14) ? 16'd15 : 16'd0);

        // Galois, built-in taps (load with mode change: load wins)
        drive(1'b0, 1'b1, 4'h1, 2'b01, 4'h0, "t2_load", 4'h1, 1'b0, 1'b0, 1'b0, 16'd15);
        for (int i = 0; i < 15; i++)
            drive(1'b1, 1'b0, 4'h1, 2'b01, 4'h0, $sformatf("t2_gal%0d", i), gal_s[i],
                  i == 14, 1'b0, i == 14, 16'd15);

        // Custom taps 8: period 4, then a mid-run taps change
        drive(1'b0, 1'b1, 4'h1, 2'b10, 4'h8, "t3_load", 4'h1, 1'b0, 1'b0, 1'b0, 16'd15);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b0, 4'h1, 2'b10, 4'h8, $sformatf("t3_cus%0d", i), cus8_s[i],
                  i == 3, 1'b0, i >= 3, (i >= 3) ? 16'd4 : 16'd15);
        drive(1'b1, 1'b0, 4'h1, 2'b10, 4'hC, "t3_cfgchg", 4'h2, 1'b0, 1'b0, 1'b0, 16'd4);
        for (int i = 0; i < 15; i++)
            drive(1'b1, 1'b0, 4'h1, 2'b10, 4'hC, $sformatf("t3_ref%0d", i), fib_s[(i + 1) % 15],
                  i == 14, 1'b0, i == 14, (i == 14) ? 16'd15 : 16'd4);

        // Custom taps 4 from seed 8 falls into zero; lockup recovery; zero seed
        drive(1'b0, 1'b1, 4'h8, 2'b10, 4'h4, "t4_load", 4'h8, 1'b0, 1'b0, 1'b0, 16'd15);
        drive(1'b1, 1'b0, 4'h8, 2'b10, 4'h4, "t4_to_zero", 4'h0, 1'b0, 1'b0, 1'b0, 16'd15);
        drive(1'b1, 1'b0, 4'h8, 2'b10, 4'h4, "t4_lockup", 4'h8, 1'b0, 1'b1, 1'b0, 16'd15);
        drive(1'b0, 1'b0, 4'h8, 2'b10, 4'h4, "t4_hold", 4'h8, 1'b0, 1'b0, 1'b0, 16'd15);
        drive(1'b0, 1'b1, 4'h0, 2'b10, 4'h4, "t4_zero_seed", 4'h1, 1'b0, 1'b1, 1'b0, 16'd15);
        drive(1'b0, 1'b0, 4'h0, 2'b10, 4'h4, "t4_after", 4'h1, 1'b0, 1'b0, 1'b0, 16'd15);

        // Load with en high: no step, count restarts (full period from 5)
        drive(1'b1, 1'b1, 4'h5, 2'b00, 4'h0, "t6_load_en", 4'h5, 1'b0, 1'b0, 1'b0, 16'd15);
        for (int i = 0; i < 15; i++)
            drive(1'b1, 1'b0, 4'h5, 2'b00, 4'h0, $sformatf("t6_fib%0d", i), fib_s[(i + 8) % 15],
                  i == 14, 1'b0, i == 14, 16'd15);
        drive(1'b1, 1'b0, 4'h5, 2'b00, 4'h0, "t6_run0", 4'hB, 1'b0, 1'b0, 1'b1, 16'd15);
        drive(1'b1, 1'b0, 4'h5, 2'b00, 4'h0, "t6_run1", 4'h7, 1'b0, 1'b0, 1'b1, 16'd15);
        drive(1'b0, 1'b0, 4'h5, 2'b00, 4'h0, "t6_en_off", 4'h7, 1'b0, 1'b0, 1'b1, 16'd15);

        // Asynchronous reset mid-run
        drive(1'b1, 1'b0, 4'h5, 2'b00, 4'h0, "t7_async_reset", 4'h1, 1'b0, 1'b0, 1'b0, 16'd0);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if4.en = 1'b0;
        drive(1'b1, 1'b0, 4'h5, 2'b00, 4'h0, "t7_after_reset", 4'h2, 1'b0, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 1'b0, 4'h5, 2'b00, 4'h0, "t7_idle", 4'h2, 1'b0, 1'b0, 1'b0, 16'd0);

        // Long runs: 8-bit with saturating 4-bit counter, 16-bit default
        @(negedge clk);
        if8.load = 1'b1;  if8.seed_in = 8'h01;     if8.en = 1'b1;
        if16.load = 1'b1; if16.seed_in = 16'h0001; if16.en = 1'b1;
        le.steps = 255;   le.per = 15;    lq8.push_back(le);
        le.steps = 65535; le.per = 65535; lq16.push_back(le);
        @(negedge clk);
        if8.load = 1'b0; if16.load = 1'b0;
        run8 = 1'b1; run16 = 1'b1;
        for (int c = 0; c < 70000 && (lq8.size() > 0 || lq16.size() > 0); c++) begin
            @(negedge clk);
            if (lq8.size() == 0) begin
                if8.en = 1'b0; run8 = 1'b0;
            end
            if (lq16.size() == 0) begin
                if16.en = 1'b0; run16 = 1'b0;
            end
        end
        if (lq8.size() > 0 || lq16.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL long_timeout: got pending w8=%0d w16=%0d after budget, want 0 0",
                     lq8.size(), lq16.size());
        end
        run8 = 1'b0; run16 = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
